// File: rtl/fetch_ctrl.sv
// Program counter and control-flow stage: PC, branch-target table, carry flag
// and a start/run/done sequencer for the 8-bit datapath.
module fetch_ctrl #(
  parameter int unsigned PC_W   = 10,
  parameter int unsigned LUT_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic              stall,
  input  logic              jump_en,
  input  logic              branch_en,
  input  logic              branch_flag,
  input  logic [LUT_AW-1:0] tgt_idx,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  input  logic              carry_we,
  input  logic              carry_d,
  output logic              carry_q,
  output logic [PC_W-1:0]   pc,
  output logic              running,
  output logic              done
);

  localparam int unsigned   DEPTH  = 1 << LUT_AW;
  localparam logic [PC_W-1:0] PC_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [PC_W-1:0] pc_next;
  logic            carry_next;
  logic [PC_W-1:0] tgt_c;
  logic [PC_W-1:0] lut_mem [DEPTH];

  // Table read sees pre-write contents, so a same-index write lands next cycle.
  assign tgt_c = lut_mem[tgt_idx];

  always_comb begin
    state_next = state;
    pc_next    = pc;
    carry_next = carry_q;

    if (carry_we && !stall) begin
      carry_next = carry_d;
    end

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_RUN;
          pc_next    = '0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (halt) begin
            state_next = S_DONE;
          end else if (jump_en || (branch_en && branch_flag)) begin
            pc_next = tgt_c;
          end else if (pc == PC_MAX) begin
            // Runaway end: stop rather than wrap back to 0.
            state_next = S_DONE;
          end else begin
            pc_next = pc + PC_W'(1);
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      carry_q <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        lut_mem[i] <= '0;
      end
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      carry_q <= carry_next;
      running <= (state_next == S_RUN);
      done    <= (state_next == S_DONE);
      if (lut_we) begin
        lut_mem[lut_waddr] <= lut_wdata;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic, all compared
// each cycle against a behavioural model of the fetch stage.
module tb_fetch_ctrl;

  localparam int unsigned PC_W   = 10;
  localparam int unsigned LUT_AW = 4;
  localparam int unsigned DEPTH  = 1 << LUT_AW;
  localparam int unsigned PC_MAX = (1 << PC_W) - 1;

  logic              clk;
  logic              reset;
  logic              start;
  logic              halt;
  logic              stall;
  logic              jump_en;
  logic              branch_en;
  logic              branch_flag;
  logic [LUT_AW-1:0] tgt_idx;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_waddr;
  logic [PC_W-1:0]   lut_wdata;
  logic              carry_we;
  logic              carry_d;
  logic              carry_q;
  logic [PC_W-1:0]   pc;
  logic              running;
  logic              done;

  int checks   = 0;
  int failures = 0;

  // Model state: mode 0 = idle, 1 = running, 2 = finished.
  int unsigned m_pc;
  int          m_mode;
  bit          m_carry;
  int unsigned m_tab [DEPTH];

  fetch_ctrl #(.PC_W(PC_W), .LUT_AW(LUT_AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .halt       (halt),
    .stall      (stall),
    .jump_en    (jump_en),
    .branch_en  (branch_en),
    .branch_flag(branch_flag),
    .tgt_idx    (tgt_idx),
    .lut_we     (lut_we),
    .lut_waddr  (lut_waddr),
    .lut_wdata  (lut_wdata),
    .carry_we   (carry_we),
    .carry_d    (carry_d),
    .carry_q    (carry_q),
    .pc         (pc),
    .running    (running),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock from the inputs currently applied.
  task automatic model_step();
    int unsigned old_tgt;
    if (reset) begin
      m_pc = 0; m_mode = 0; m_carry = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) m_tab[i] = 0;
      return;
    end
    old_tgt = m_tab[tgt_idx];
    if (lut_we) m_tab[lut_waddr] = lut_wdata;
    if (carry_we && !stall) m_carry = carry_d;
    if (m_mode != 1) begin
      if (start) begin
        m_mode = 1; m_pc = 0;
      end
    end else if (!stall) begin
      if (halt) m_mode = 2;
      else if (jump_en || (branch_en && branch_flag)) m_pc = old_tgt;
      else if (m_pc == PC_MAX) m_mode = 2;
      else m_pc = m_pc + 1;
    end
  endtask

  // One clock: update model, let the edge pass, compare every output.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("pc", 32'(pc), 32'(m_pc));
    check("running", 32'(running), 32'(m_mode == 1));
    check("done", 32'(done), 32'(m_mode == 2));
    check("carry_q", 32'(carry_q), 32'(m_carry));
  endtask

  task automatic idle_inputs();
    reset = 1'b0; start = 1'b0; halt = 1'b0; stall = 1'b0;
    jump_en = 1'b0; branch_en = 1'b0; branch_flag = 1'b0; tgt_idx = '0;
    lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
    carry_we = 1'b0; carry_d = 1'b0;
  endtask

  task automatic lut_write(input int unsigned idx, input int unsigned val);
    lut_we = 1'b1; lut_waddr = LUT_AW'(idx); lut_wdata = PC_W'(val);
    tick();
    lut_we = 1'b0;
  endtask

  initial begin
    idle_inputs();
    m_pc = 0; m_mode = 0; m_carry = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) m_tab[i] = 0;

    // Reset state
    reset = 1'b1;
    tick();
    check("rst_pc_lit", 32'(pc), 32'd0);
    check("rst_done_lit", 32'(done), 32'd0);
    reset = 1'b0;

    // Sequential run and halt at pc 5
    start = 1'b1; tick(); start = 1'b0;
    check("start_pc_lit", 32'(pc), 32'd0);
    check("start_run_lit", 32'(running), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("seq_pc_lit", 32'(pc), 32'(i));
    end
    halt = 1'b1; tick(); halt = 1'b0;
    check("halt_pc_lit", 32'(pc), 32'd5);
    check("halt_done_lit", 32'(done), 32'd1);
    tick();
    check("done_hold_lit", 32'(pc), 32'd5);

    // Branches
    lut_write(3, 'h040);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("pre_br_pc_lit", 32'(pc), 32'd2);
    branch_en = 1'b1; tgt_idx = 4'd3; branch_flag = 1'b0; tick();
    check("br_not_taken_lit", 32'(pc), 32'd3);
    branch_flag = 1'b1; tick();
    check("br_taken_lit", 32'(pc), 32'h040);
    jump_en = 1'b1; branch_flag = 1'b0; tick();
    check("jump_over_br_lit", 32'(pc), 32'h040);
    jump_en = 1'b0; branch_en = 1'b0;

    // Carry capture, then stall with halt and carry_we
    carry_we = 1'b1; carry_d = 1'b1; tick();
    check("carry_set_lit", 32'(carry_q), 32'd1);
    stall = 1'b1; halt = 1'b1; carry_d = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("stall_pc_lit", 32'(pc), 32'h041);
    check("stall_carry_lit", 32'(carry_q), 32'd1);
    check("stall_run_lit", 32'(running), 32'd1);
    stall = 1'b0; carry_we = 1'b0; tick(); halt = 1'b0;
    check("unstall_halt_lit", 32'(done), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    halt = 1'b1; jump_en = 1'b1; tgt_idx = 4'd3; tick();
    halt = 1'b0; jump_en = 1'b0;
    check("halt_over_jump_pc_lit", 32'(pc), 32'd1);
    check("halt_over_jump_done_lit", 32'(done), 32'd1);

    // Table write/read hazard
    lut_write(1, 'h010);
    start = 1'b1; tick(); start = 1'b0;
    lut_we = 1'b1; lut_waddr = 4'd1; lut_wdata = 10'h020;
    jump_en = 1'b1; tgt_idx = 4'd1; tick();
    lut_we = 1'b0;
    check("hazard_old_lit", 32'(pc), 32'h010);
    tick();
    jump_en = 1'b0;
    check("hazard_new_lit", 32'(pc), 32'h020);

    // Runaway end and restart
    lut_write(2, 'h3FC);
    jump_en = 1'b1; tgt_idx = 4'd2; tick(); jump_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("runaway_pc_lit", 32'(pc), 32'h3FF);
    check("runaway_done_lit", 32'(done), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    check("restart_pc_lit", 32'(pc), 32'd0);
    check("restart_run_lit", 32'(running), 32'd1);

    // Reset mid-run dominates start and table write
    for (int i = 0; i < 7; i++) tick();
    check("pre_reset_pc_lit", 32'(pc), 32'd7);
    reset = 1'b1; start = 1'b1; lut_we = 1'b1; lut_waddr = 4'd5; lut_wdata = 10'h155;
    tick();
    idle_inputs();
    check("midrst_pc_lit", 32'(pc), 32'd0);
    check("midrst_run_lit", 32'(running), 32'd0);
    check("midrst_carry_lit", 32'(carry_q), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    jump_en = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      tgt_idx = LUT_AW'(i);
      tick();
      check("cleared_tab_lit", 32'(pc), 32'd0);
    end
    jump_en = 1'b0;

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      reset       = ($urandom_range(0, 299) == 0);
      start       = ($urandom_range(0, 19) == 0);
      halt        = ($urandom_range(0, 49) == 0);
      stall       = ($urandom_range(0, 5) == 0);
      jump_en     = ($urandom_range(0, 11) == 0);
      branch_en   = ($urandom_range(0, 7) == 0);
      branch_flag = 1'($urandom);
      tgt_idx     = LUT_AW'($urandom);
      lut_we      = ($urandom_range(0, 4) == 0);
      lut_waddr   = LUT_AW'($urandom);
      lut_wdata   = ($urandom_range(0, 3) == 0) ? PC_W'(PC_MAX - $urandom_range(0, 3))
                                                : PC_W'($urandom);
      carry_we    = ($urandom_range(0, 2) == 0);
      carry_d     = 1'($urandom);
      tick();
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Program-counter and control-flow stage for the 8-bit datapath. Holds the PC and a small branch-target lookup table. Consumes the ALU's `branchFlag` and `shiftcarry_out` each cycle. Drives the instruction-fetch address and feeds the registered carry back to the ALU's `shiftcarry_in`, with a start/done handshake to the testbench or top level.

## Interface

**Parameters**
- `PC_W`, default 10: PC width in bits.
- `LUT_AW`, default 4: target-table index width, giving 2^LUT_AW entries of `PC_W` bits.

**Ports** (one clock; reset is synchronous and active-high)
- `clk`, in, 1: sole clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: one-cycle request to begin execution at PC 0.
- `halt`, in, 1: current instruction is a halt.
- `stall`, in, 1: freeze the PC, FSM and carry this cycle.
- `jump_en`, in, 1: unconditional jump through the table.
- `branch_en`, in, 1: conditional branch through the table.
- `branch_flag`, in, 1: ALU compare result, same cycle.
- `tgt_idx`, in, `LUT_AW`: table index for jump or branch.
- `lut_we`, in, 1: table write enable.
- `lut_waddr`, in, `LUT_AW`: table write index.
- `lut_wdata`, in, `PC_W`: absolute target address.
- `carry_we`, in, 1: capture `carry_d` into the carry flag.
- `carry_d`, in, 1: from the ALU `shiftcarry_out`.
- `carry_q`, out, 1: registered carry, to the ALU `shiftcarry_in`.
- `pc`, out, `PC_W`: instruction-fetch address (registered).
- `running`, out, 1: FSM is in RUN.
- `done`, out, 1: FSM is in DONE.

## Operation

**Reset values**
- `pc` = 0, `carry_q` = 0, `running` = 0, `done` = 0, FSM = IDLE.
- All table entries = 0.

**FSM**
- **IDLE**
  - `start` goes to RUN and sets `pc` to 0.
  - All other control inputs are ignored.
- **RUN**
  - When `stall` = 1, nothing changes: `pc`, FSM and `carry_q` are held, and `halt`, `jump_en`, `branch_en` and `carry_we` are ignored.
  - Otherwise the next PC is chosen by priority:
    1. `halt`: go to DONE, `pc` held.
    2. `jump_en`: `pc` ← `table[tgt_idx]`.
    3. `branch_en` with `branch_flag` = 1: `pc` ← `table[tgt_idx]`.
    4. Otherwise (including a branch not taken): `pc` ← `pc` + 1.
  - Runaway end: if `pc` = 2^PC_W−1 and rule 4 applies, go to DONE with `pc` held. The PC never wraps to 0.
  - `start` is ignored.
- **DONE**
  - `done` = 1 and `pc` is held.
  - `start` goes to RUN with `pc` = 0 and `done` cleared. The table is kept; `carry_q` is kept.

**Target table**
- Written when `lut_we` = 1, in any state, regardless of `stall`.
- The read is combinational from the current contents.
- If a write and a jump/branch use the same index in the same cycle, the jump/branch uses the old entry; the new value applies from the next cycle.

**Carry flag**
- `carry_q` ← `carry_d` when `carry_we` = 1 and `stall` = 0, in any state.
- Upstream asserts `carry_we` only for shift, add and subtract (the ALU carry is undefined otherwise).

**Width rules**
- The PC increment is `PC_W` bits unsigned.
- Table entries are absolute addresses with no offset arithmetic.

## Timing
- Every output comes straight from a register; no combinational input-to-output paths.
- A control decision in cycle N appears on `pc` in cycle N+1.
- `branch_flag` must settle within cycle N.
- Start latency is 1 cycle: `start` in cycle N gives `running` = 1 and `pc` = 0 in cycle N+1.
- `halt` in cycle N gives `done` = 1 and `running` = 0 in cycle N+1.
- `reset` dominates `start`, `stall` and `lut_we` in the same cycle, including mid-RUN: the next cycle shows the full reset state and a cleared table.
- `carry_q` appears 1 cycle after `carry_we`.

## Test plan
1. **Sequential run:** reset, then `start` → `pc` = 0, 1, 2, … on successive cycles. Assert `halt` when `pc` = 5 → `pc` stays at 5, `done` = 1 from the next cycle.
2. **Branches:** write `table[3]` = 0x040, then `start`.
   - At `pc` = 2: `branch_en` = 1, `tgt_idx` = 3, `branch_flag` = 0 → `pc` = 3.
   - At `pc` = 3: `branch_flag` = 1 → `pc` = 0x040.
   - `jump_en` with `branch_en` and `branch_flag` = 0 → jump still taken.
3. **Stall and priority:**
   - `stall` for 3 cycles with `halt` = 1 and `carry_we` = 1 → `pc`, FSM and `carry_q` unchanged.
   - Release `stall` with `halt` = 1 → DONE next cycle.
   - Same cycle `halt` = 1 and `jump_en` = 1 → DONE, `pc` unchanged.
4. **Table hazard:** `table[1]` = 0x010. In the same cycle: write `table[1]` = 0x020 and `jump_en` with `tgt_idx` = 1 → `pc` = 0x010. A later jump to index 1 → `pc` = 0x020.
5. **Runaway end and restart:** `PC_W` = 4, run with no control inputs → `pc` reaches 15, then `done` = 1 with `pc` = 15. Then `start` → `pc` = 0, `running` = 1.
6. **Reset mid-run and carry:**
   - `carry_we` = 1, `carry_d` = 1 → `carry_q` = 1 next cycle.
   - At `pc` = 7 while running, assert `reset` → next cycle `pc` = 0, IDLE, `carry_q` = 0, all table entries read 0.
